// File: rtl/hamming_byte_assembler.sv
// Pairs decoded Hamming(8,4) nibbles (low first) into bytes with merged SEC/DED flags,
// and keeps saturating per-nibble error counts.
module hamming_byte_assembler #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_data,
   input  logic             in_sec,
   input  logic             in_ded,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_byte,
   output logic             out_sec,
   output logic             out_ded,
   input  logic             clr_counts,
   output logic [CNT_W-1:0] sec_count,
   output logic [CNT_W-1:0] ded_count
);

   typedef enum logic {
      WAIT_LO = 1'b0,
      WAIT_HI = 1'b1
   } state_t;

   state_t           state_q;
   logic [3:0]       loData_q;
   logic             loSec_q;
   logic             loDed_q;
   logic             outValid_q;
   logic [7:0]       outByte_q;
   logic             outSec_q;
   logic             outDed_q;
   logic [CNT_W-1:0] secCount_q, secCount_d;
   logic [CNT_W-1:0] dedCount_q, dedCount_d;
   logic             accept;

   // Only the high nibble needs room in the output register, so WAIT_LO never stalls.
   assign in_ready = (state_q == WAIT_LO) || !outValid_q || out_ready;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= WAIT_LO;
         loData_q   <= 4'h0;
         loSec_q    <= 1'b0;
         loDed_q    <= 1'b0;
         outValid_q <= 1'b0;
         outByte_q  <= 8'h00;
         outSec_q   <= 1'b0;
         outDed_q   <= 1'b0;
      end else begin
         if (outValid_q && out_ready) begin
            outValid_q <= 1'b0;
         end
         case (state_q)
            WAIT_LO: begin
               if (accept) begin
                  loData_q <= in_data;
                  loSec_q  <= in_sec;
                  loDed_q  <= in_ded;
                  state_q  <= WAIT_HI;
               end
            end
            WAIT_HI: begin
               // A load in the same cycle as a drain keeps out_valid high with the new byte.
               if (accept) begin
                  outByte_q  <= {in_data, loData_q};
                  outSec_q   <= in_sec | loSec_q;
                  outDed_q   <= in_ded | loDed_q;
                  outValid_q <= 1'b1;
                  state_q    <= WAIT_LO;
               end
            end
            default: state_q <= WAIT_LO;
         endcase
      end
   end

   always_comb begin
      secCount_d = secCount_q;
      dedCount_d = dedCount_q;
      if (clr_counts) begin
         secCount_d = '0;
         dedCount_d = '0;
      end else if (accept) begin
         if (in_sec && (secCount_q != {CNT_W{1'b1}})) secCount_d = secCount_q + CNT_W'(1);
         if (in_ded && (dedCount_q != {CNT_W{1'b1}})) dedCount_d = dedCount_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         secCount_q <= '0;
         dedCount_q <= '0;
      end else begin
         secCount_q <= secCount_d;
         dedCount_q <= dedCount_d;
      end
   end

   assign out_valid = outValid_q;
   assign out_byte  = outByte_q;
   assign out_sec   = outSec_q;
   assign out_ded   = outDed_q;
   assign sec_count = secCount_q;
   assign ded_count = dedCount_q;

endmodule

// File: tb/tb_hamming_byte_assembler.sv
// Bench for hamming_byte_assembler: directed scenarios plus a random run against a
// nibble-pairing reference model; a 2-bit-counter instance shares the stimulus for saturation.
module tb_hamming_byte_assembler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [3:0] in_data = 4'h0;
   logic       in_sec = 1'b0;
   logic       in_ded = 1'b0;
   logic       out_ready = 1'b0;
   logic       clr_counts = 1'b0;

   logic        inReady, outValid, outSec, outDed;
   logic [7:0]  outByte;
   logic [15:0] secCount, dedCount;
   logic        inReady2, outValid2, outSec2, outDed2;
   logic [7:0]  outByte2;
   logic [1:0]  secCount2, dedCount2;

   int checks = 0;
   int errors = 0;

   hamming_byte_assembler #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady),
      .in_data(in_data), .in_sec(in_sec), .in_ded(in_ded),
      .out_valid(outValid), .out_ready(out_ready), .out_byte(outByte),
      .out_sec(outSec), .out_ded(outDed), .clr_counts(clr_counts),
      .sec_count(secCount), .ded_count(dedCount)
   );

   hamming_byte_assembler #(.CNT_W(2)) dutSmall (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady2),
      .in_data(in_data), .in_sec(in_sec), .in_ded(in_ded),
      .out_valid(outValid2), .out_ready(out_ready), .out_byte(outByte2),
      .out_sec(outSec2), .out_ded(outDed2), .clr_counts(clr_counts),
      .sec_count(secCount2), .ded_count(dedCount2)
   );

   // Reference model: an optional held low nibble, a one-byte output slot, unbounded counts.
   bit         mHaveLo = 0;
   logic [3:0] mLo = 4'h0;
   bit         mLoSec = 0, mLoDed = 0;
   bit         mOutValid = 0;
   logic [7:0] mByte = 8'h00;
   bit         mSec = 0, mDed = 0;
   longint     mSecCnt = 0, mDedCnt = 0;

   function automatic bit modelReady();
      return !mHaveLo || !mOutValid || out_ready;
   endfunction

   function automatic longint satAt(longint c, int w);
      longint m;
      m = (longint'(1) << w) - 1;
      return (c > m) ? m : c;
   endfunction

   task automatic applyStimulus(input bit v, input logic [3:0] d, input bit s, input bit dd,
                                input bit o, input bit c);
      in_valid   = v;
      in_data    = d;
      in_sec     = s;
      in_ded     = dd;
      out_ready  = o;
      clr_counts = c;
      #1;
   endtask

   // Advances one clock and moves the model by the same rules, then lets outputs settle.
   task automatic tick();
      bit acc;
      acc = in_valid && modelReady();
      @(posedge clk);
      if (rst) begin
         mHaveLo = 0; mLo = 4'h0; mLoSec = 0; mLoDed = 0;
         mOutValid = 0; mByte = 8'h00; mSec = 0; mDed = 0;
         mSecCnt = 0; mDedCnt = 0;
      end else begin
         if (mOutValid && out_ready) mOutValid = 0;
         if (acc) begin
            if (mHaveLo) begin
               mByte = {in_data, mLo};
               mSec = in_sec | mLoSec;
               mDed = in_ded | mLoDed;
               mOutValid = 1;
               mHaveLo = 0;
            end else begin
               mLo = in_data; mLoSec = in_sec; mLoDed = in_ded;
               mHaveLo = 1;
            end
         end
         if (clr_counts) begin
            mSecCnt = 0; mDedCnt = 0;
         end else if (acc) begin
            if (in_sec) mSecCnt++;
            if (in_ded) mDedCnt++;
         end
      end
      #1;
   endtask

   task automatic doReset();
      rst = 1'b1;
      applyStimulus(0, 4'h0, 0, 0, 1, 0);
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      applyStimulus(1, 4'hC, 1, 1, 0, 0);
      tick();
      tick();
      rst = 1'b0;
      applyStimulus(0, 4'h0, 0, 0, 0, 0);
      checks += 8;
      if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", outValid); end
      if (outByte !== 8'h00) begin errors++; $display("[TB] FAIL reset_byte got %h want 00", outByte); end
      if (outSec !== 1'b0) begin errors++; $display("[TB] FAIL reset_sec got %b want 0", outSec); end
      if (outDed !== 1'b0) begin errors++; $display("[TB] FAIL reset_ded got %b want 0", outDed); end
      if (secCount !== 16'd0) begin errors++; $display("[TB] FAIL reset_seccnt got %0d want 0", secCount); end
      if (dedCount !== 16'd0) begin errors++; $display("[TB] FAIL reset_dedcnt got %0d want 0", dedCount); end
      if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", inReady); end
      if (secCount2 !== 2'd0) begin errors++; $display("[TB] FAIL reset_seccnt2 got %0d want 0", secCount2); end
   endtask

   task automatic test_basic();
      doReset();
      applyStimulus(1, 4'hA, 0, 0, 1, 0);
      tick();
      applyStimulus(1, 4'h5, 0, 0, 1, 0);
      checks++;
      if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL basic_half got valid %b want 0", outValid); end
      tick();
      applyStimulus(0, 4'h0, 0, 0, 1, 0);
      checks += 4;
      if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid got %b want 1", outValid); end
      if (outByte !== 8'h5A) begin errors++; $display("[TB] FAIL basic_byte got %h want 5a", outByte); end
      if (outSec !== 1'b0) begin errors++; $display("[TB] FAIL basic_sec got %b want 0", outSec); end
      if (outDed !== 1'b0) begin errors++; $display("[TB] FAIL basic_ded got %b want 0", outDed); end
      tick();
      checks += 2;
      if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL basic_drain got %b want 0", outValid); end
      if (secCount !== 16'd0 || dedCount !== 16'd0) begin
         errors++; $display("[TB] FAIL basic_counts got %0d/%0d want 0/0", secCount, dedCount);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] nib [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
      bit         sArr [4] = '{0, 1, 0, 0};
      bit         dArr [4] = '{0, 0, 1, 0};
      doReset();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, nib[i], sArr[i], dArr[i], 1, 0);
         tick();
         if (i == 1) begin
            checks++;
            if ({outValid, outByte, outSec, outDed} !== {1'b1, 8'h21, 1'b1, 1'b0}) begin
               errors++; $display("[TB] FAIL b2b_first got v%b %h s%b d%b want v1 21 s1 d0", outValid, outByte, outSec, outDed);
            end
         end else if (i == 2) begin
            checks++;
            if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_gap got %b want 0", outValid); end
         end else if (i == 3) begin
            checks++;
            if ({outValid, outByte, outSec, outDed} !== {1'b1, 8'h43, 1'b0, 1'b1}) begin
               errors++; $display("[TB] FAIL b2b_second got v%b %h s%b d%b want v1 43 s0 d1", outValid, outByte, outSec, outDed);
            end
         end
      end
      applyStimulus(0, 4'h0, 0, 0, 1, 0);
      checks++;
      if (secCount !== 16'd1 || dedCount !== 16'd1) begin
         errors++; $display("[TB] FAIL b2b_counts got %0d/%0d want 1/1", secCount, dedCount);
      end
   endtask

   task automatic test_backpressure();
      doReset();
      applyStimulus(1, 4'h1, 0, 0, 0, 0);
      tick();
      applyStimulus(1, 4'h2, 0, 0, 0, 0);
      tick();
      applyStimulus(1, 4'h3, 0, 0, 0, 0);
      checks++;
      if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL bp_lo_ready got %b want 1", inReady); end
      tick();
      checks++;
      if (outValid !== 1'b1 || outByte !== 8'h21) begin
         errors++; $display("[TB] FAIL bp_hold1 got v%b %h want v1 21", outValid, outByte);
      end
      applyStimulus(1, 4'h4, 0, 0, 0, 0);
      checks++;
      if (inReady !== 1'b0) begin errors++; $display("[TB] FAIL bp_stall got %b want 0", inReady); end
      tick();
      checks++;
      if (outValid !== 1'b1 || outByte !== 8'h21) begin
         errors++; $display("[TB] FAIL bp_hold2 got v%b %h want v1 21", outValid, outByte);
      end
      applyStimulus(1, 4'h4, 0, 0, 1, 0);
      checks++;
      if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL bp_release got %b want 1", inReady); end
      tick();
      checks++;
      if (outValid !== 1'b1 || outByte !== 8'h43) begin
         errors++; $display("[TB] FAIL bp_swap got v%b %h want v1 43", outValid, outByte);
      end
      applyStimulus(0, 4'h0, 0, 0, 1, 0);
      tick();
   endtask

   task automatic test_reset_mid();
      doReset();
      applyStimulus(1, 4'hF, 0, 0, 1, 0);
      tick();
      rst = 1'b1;
      applyStimulus(0, 4'h0, 0, 0, 1, 0);
      tick();
      rst = 1'b0;
      applyStimulus(1, 4'h1, 0, 0, 1, 0);
      tick();
      checks++;
      if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_lo got valid %b want 0", outValid); end
      applyStimulus(1, 4'h2, 0, 0, 1, 0);
      tick();
      checks++;
      if (outValid !== 1'b1 || outByte !== 8'h21) begin
         errors++; $display("[TB] FAIL rmid_byte got v%b %h want v1 21", outValid, outByte);
      end
   endtask

   task automatic test_saturation();
      int exp2;
      doReset();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 4'($urandom_range(0, 15)), 1, 0, 1, 0);
         tick();
         exp2 = (i + 1 > 3) ? 3 : i + 1;
         checks += 2;
         if (int'(secCount2) != exp2) begin
            errors++; $display("[TB] FAIL sat_cnt2 step %0d got %0d want %0d", i, secCount2, exp2);
         end
         if (int'(secCount) != i + 1) begin
            errors++; $display("[TB] FAIL sat_cnt16 step %0d got %0d want %0d", i, secCount, i + 1);
         end
      end
      applyStimulus(1, 4'h9, 1, 1, 1, 1);
      tick();
      checks += 2;
      if (secCount2 !== 2'd0 || dedCount2 !== 2'd0) begin
         errors++; $display("[TB] FAIL sat_clr2 got %0d/%0d want 0/0", secCount2, dedCount2);
      end
      if (secCount !== 16'd0 || dedCount !== 16'd0) begin
         errors++; $display("[TB] FAIL sat_clr16 got %0d/%0d want 0/0", secCount, dedCount);
      end
   endtask

   task automatic test_idle();
      bit         vArr [4] = '{1, 0, 0, 1};
      logic [3:0] dArr [4] = '{4'h7, 4'hE, 4'hD, 4'h8};
      doReset();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(vArr[i], dArr[i], 0, 0, 1, 0);
         tick();
         checks++;
         if (i < 3) begin
            if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL idle_gap%0d got %b want 0", i, outValid); end
         end else begin
            if (outValid !== 1'b1 || outByte !== 8'h87) begin
               errors++; $display("[TB] FAIL idle_byte got v%b %h want v1 87", outValid, outByte);
            end
         end
      end
   endtask

   task automatic test_random();
      bit expReady;
      doReset();
      for (int cyc = 0; cyc < 500; cyc++) begin
         rst = ($urandom_range(0, 59) == 0);
         applyStimulus($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                       $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
         expReady = modelReady();
         checks++;
         if (inReady !== expReady) begin
            errors++; $display("[TB] FAIL rnd_ready cyc %0d got %b want %b", cyc, inReady, expReady);
         end
         tick();
         rst = 1'b0;
         checks += 4;
         if (outValid !== mOutValid) begin
            errors++; $display("[TB] FAIL rnd_valid cyc %0d got %b want %b", cyc, outValid, mOutValid);
         end
         if ({outByte, outSec, outDed} !== {mByte, mSec, mDed}) begin
            errors++; $display("[TB] FAIL rnd_data cyc %0d got %h s%b d%b want %h s%b d%b",
                               cyc, outByte, outSec, outDed, mByte, mSec, mDed);
         end
         if (longint'(secCount) != satAt(mSecCnt, 16) || longint'(dedCount) != satAt(mDedCnt, 16)) begin
            errors++; $display("[TB] FAIL rnd_cnt16 cyc %0d got %0d/%0d want %0d/%0d",
                               cyc, secCount, dedCount, satAt(mSecCnt, 16), satAt(mDedCnt, 16));
         end
         if (longint'(secCount2) != satAt(mSecCnt, 2) || longint'(dedCount2) != satAt(mDedCnt, 2)) begin
            errors++; $display("[TB] FAIL rnd_cnt2 cyc %0d got %0d/%0d want %0d/%0d",
                               cyc, secCount2, dedCount2, satAt(mSecCnt, 2), satAt(mDedCnt, 2));
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_saturation();
      test_idle();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
